// File: rtl/cpm_pkg.sv
// Shared types and constants for the count progress monitor.
package cpm_pkg;
  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_STUCK    = 2'b01;
  localparam logic [1:0] FC_SKIP     = 2'b10;
  localparam logic [1:0] FC_SPURIOUS = 2'b11;

  localparam int CNT_W = 8;
endpackage

// File: rtl/cpm_stall_timer.sv
// Consecutive no-change counter with a limit compare on the next value.
module cpm_stall_timer
  import cpm_pkg::*;
#(
  parameter int STALL_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] nxt;

  assign nxt = cnt + CNT_W'(1);
  // Fires on the edge whose increment reaches the limit
  assign hit = inc && (nxt == LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hold) begin
      cnt <= nxt;
    end
  end
endmodule

// File: rtl/count_progress_monitor.sv
// Checks a free-running counter steps by STEP per enabled cycle;
// latches stuck, skip and spurious faults until cleared.
module count_progress_monitor
  import cpm_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STEP        = 1,
  parameter int STALL_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_en,
  input  logic             clr_fault,
  output logic             monitor_active,
  output logic             fault_valid,
  output logic [1:0]       fault_code,
  output logic [WIDTH-1:0] last_good,
  output logic [7:0]       stall_cnt,
  output logic [7:0]       advance_cnt
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             en_d;
  logic [WIDTH-1:0] delta;
  logic             trk;
  logic             good;
  logic             still;
  logic             skip;
  logic             spur;
  logic             hit;
  logic             st_clr;
  logic             st_hold;
  logic             stuck;

  assign delta = count_in - prev;
  assign trk   = (state == TRACK);

  // With STEP==0 a zero delta is a good step, so still never fires
  always_comb begin
    good    = trk && en_d && (delta == STEP_W);
    still   = trk && en_d && (delta == '0) && !good;
    skip    = trk && en_d && !good && !still;
    spur    = trk && !en_d && (delta != '0);
    st_clr  = good || ((state == FAULT) && clr_fault);
    st_hold = !trk;
    stuck   = still && hit;
  end

  cpm_stall_timer #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (still),
    .clr (st_clr),
    .hold(st_hold),
    .cnt (stall_cnt),
    .hit (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prev           <= '0;
      en_d           <= 1'b0;
      last_good      <= '0;
      advance_cnt    <= '0;
      fault_valid    <= 1'b0;
      fault_code     <= FC_NONE;
      monitor_active <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (count_en) begin
            prev           <= count_in;
            en_d           <= 1'b1;
            last_good      <= count_in;
            monitor_active <= 1'b1;
            state          <= TRACK;
          end
        end
        TRACK: begin
          prev <= count_in;
          en_d <= count_en;
          if (good) begin
            last_good <= count_in;
            if (advance_cnt != 8'hFF) begin
              advance_cnt <= advance_cnt + 8'd1;
            end
          end
          unique case (1'b1)
            stuck: begin
              fault_code <= FC_STUCK;
              fault_valid <= 1'b1;
              monitor_active <= 1'b0;
              state <= FAULT;
            end
            skip: begin
              fault_code <= FC_SKIP;
              fault_valid <= 1'b1;
              monitor_active <= 1'b0;
              state <= FAULT;
            end
            spur: begin
              fault_code <= FC_SPURIOUS;
              fault_valid <= 1'b1;
              monitor_active <= 1'b0;
              state <= FAULT;
            end
            default: ;
          endcase
        end
        FAULT: begin
          if (clr_fault) begin
            fault_valid <= 1'b0;
            fault_code  <= FC_NONE;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/count_progress_monitor.md
Name: count_progress_monitor

Overview:
- Consumer stage placed directly downstream of a free-running up-counter in the sequential test circuits.
- Samples the counter value every clock and checks that it advances by exactly STEP on each enabled cycle and holds when disabled.
- Reports stuck, skipped and spurious counts as a sticky fault with a code and the last good value, so a stuck counter is caught in hardware rather than by reading a monitor log.

Parameters:
- WIDTH, 4, width of the monitored count.
- STEP, 1, expected increment per enabled cycle, modulo 2^WIDTH.
- STALL_LIMIT, 3, consecutive enabled cycles with no change before STUCK is declared (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  counter value under observation.
- count_en  input  1  high means the counter is expected to advance on this clock edge.
- clr_fault  input  1  one-cycle pulse that clears a latched fault.
- monitor_active  output  1  high while tracking.
- fault_valid  output  1  sticky fault flag.
- fault_code  output  2  00 NONE, 01 STUCK, 10 SKIP, 11 SPURIOUS.
- last_good  output  WIDTH  last count_in accepted as a correct step.
- stall_cnt  output  8  current consecutive no-change count.
- advance_cnt  output  8  number of good steps, saturating at 255.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high, sampled only on the rising edge of clk.
  - Reset outputs: monitor_active=0, fault_valid=0, fault_code=00, last_good=0, stall_cnt=0, advance_cnt=0.
  - Reset also clears internal state: state=IDLE, prev=0, en_d=0.
  - rst takes priority over every other input, including mid-fault and mid-stall; the next edge returns all state to these values.
- Internal registers: prev (count_in sampled at the previous edge) and en_d (count_en sampled at the previous edge).
- Step arithmetic: delta = (count_in - prev) mod 2^WIDTH, unsigned and WIDTH bits wide. The wrap from max to 0 with STEP=1 is therefore a good step.
- IDLE:
  - While count_en=0: stay in IDLE, keep outputs, capture nothing.
  - On the first edge with count_en=1: capture prev=count_in, en_d=1, last_good=count_in, then move to TRACK.
- TRACK (monitor_active=1). Every edge sets prev<=count_in and en_d<=count_en. Comparison uses the old prev and en_d:
  - en_d=1, delta==STEP: good step. stall_cnt<=0, advance_cnt++ (saturating), last_good<=count_in.
  - en_d=1, delta==0: stall_cnt++. When the incremented value equals STALL_LIMIT, go to FAULT with code STUCK.
  - en_d=1, any other delta: go to FAULT with code SKIP immediately.
  - en_d=0, delta==0: hold; stall_cnt is unchanged.
  - en_d=0, delta!=0: go to FAULT with code SPURIOUS.
  - If STEP==0, STUCK detection is disabled and delta 0 counts as a good step.
- FAULT:
  - fault_valid=1 and fault_code are valid starting the cycle after the detecting edge.
  - monitor_active=0; all counters freeze; no further detection runs.
  - clr_fault=1 at an edge clears fault_valid, fault_code and stall_cnt and moves to IDLE. advance_cnt and last_good are kept.
  - clr_fault outside FAULT is ignored.
- Latency:
  - A fault is flagged one edge after the offending sample.
  - STUCK is flagged STALL_LIMIT edges after the baseline capture when the counter never moves.
- Simultaneous events:
  - rst beats clr_fault.
  - A fault detected on an edge where clr_fault is also high is still latched, because clr_fault only acts in FAULT.

Decomposition:
- Package cpm_pkg holds:
  - state enum: IDLE, TRACK, FAULT;
  - fault code constants: FC_NONE, FC_STUCK, FC_SKIP, FC_SPURIOUS;
  - the 8-bit counter width constant.
- One natural sub-module, cpm_stall_timer:
  - an 8-bit consecutive-stall counter with inc, clr and hold inputs;
  - a compare output that fires when the count reaches STALL_LIMIT.
- The top-level block holds the FSM, the delta logic and the advance counter.

Test Plan:
- Stuck counter: rst=1 for one edge; then count_en=1 continuously with count_in held at 0. Baseline is captured at the first edge after rst. fault_valid=1 and fault_code=01 appear after 3 more edges, with stall_cnt=3 and last_good=0.
- Good count with wrap: count_en=1 and count_in 0,1,...,15,0,1 over 18 edges. fault_valid stays 0, advance_cnt=17 and last_good=1.
- Skip: count_in 3,4,6 with count_en=1. fault_code=10 after the edge that samples 6; last_good=4 and advance_cnt=1.
- Spurious: count_en goes 1 then 0 while count_in runs 5,6,7. fault_code=11 after the edge that samples 7.
- Clear and reset mid-operation:
  - After a STUCK fault, pulse clr_fault. The block returns to IDLE and fault_valid=0 while advance_cnt is kept.
  - Then pulse rst mid-TRACK with stall_cnt=2. The next edge gives all outputs 0 and monitor_active=0.
